// File: rtl/mul_pkg.sv
// Shared types and constants for the pipelined multiplier.
package mul_pkg;

    // Upper bound on the number of register stages in the pipe.
    localparam int MUL_MAX_LATENCY = 8;

    // Multiply mode as encoded on req_mode.
    typedef enum logic [1:0] {
        MUL   = 2'b00,  // signed x signed, low half
        MULU  = 2'b01,  // unsigned x unsigned, low half
        MULH  = 2'b10,  // signed x signed, high half
        MULHU = 2'b11   // unsigned x unsigned, high half
    } mul_mode_t;

    // Operands are sign-extended for the signed modes, zero-extended otherwise.
    function automatic logic mode_is_signed(input mul_mode_t mode);
        return (mode == MUL) || (mode == MULH);
    endfunction

    // High-half modes return the upper DATA_WIDTH bits of the product.
    function automatic logic mode_is_high(input mul_mode_t mode);
        return (mode == MULH) || (mode == MULHU);
    endfunction

    // Keeps an out-of-range LATENCY parameter inside 1..MUL_MAX_LATENCY.
    function automatic int clamp_latency(input int latency);
        if (latency < 1) begin
            return 1;
        end
        if (latency > MUL_MAX_LATENCY) begin
            return MUL_MAX_LATENCY;
        end
        return latency;
    endfunction

endpackage

// File: rtl/mul_pipe_stage.sv
// One valid/ready register slice of the multiplier pipe. The ready path is
// combinational so a stall at the output ripples back through every slice
// in the same cycle, while empty slices (bubbles) keep accepting.
module mul_pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_reg;
    logic [WIDTH-1:0] data_reg;

    // Loadable when empty or when the current contents move on; never during a flush.
    assign in_ready = (!valid_reg || out_ready) && !flush;

    // Slice register: flush only clears the valid bit, the payload is left as is.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (in_ready) begin
            valid_reg <= in_valid;
            if (in_valid) begin
                data_reg <= in_data;
            end
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;

endmodule

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier with per-stage valid/ready backpressure.
// The product, operand extension and overflow detection are combinational
// in front of the first slice; the remaining slices only carry registers
// so synthesis is free to retime the multiplier across them.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 3,
    parameter int ROB_ID_WIDTH  = 4,
    parameter int PC_WIDTH      = 32,
    parameter int RF_ADDR_WIDTH = 5,
    parameter int XCPT_WIDTH    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_mode,
    input  logic [DATA_WIDTH-1:0]    req_src_a,
    input  logic [DATA_WIDTH-1:0]    req_src_b,
    input  logic [ROB_ID_WIDTH-1:0]  req_rob_id,
    input  logic [PC_WIDTH-1:0]      req_pc,
    input  logic [RF_ADDR_WIDTH-1:0] req_rd,
    input  logic [XCPT_WIDTH-1:0]    req_xcpt,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [ROB_ID_WIDTH-1:0]  rsp_rob_id,
    output logic [PC_WIDTH-1:0]      rsp_pc,
    output logic [RF_ADDR_WIDTH-1:0] rsp_rd,
    output logic [XCPT_WIDTH-1:0]    rsp_xcpt,
    output logic                     rsp_overflow,
    output logic                     busy
);

    localparam int STAGES = clamp_latency(LATENCY);

    // Payload carried by every slice; the valid bit lives in the slice itself.
    // The selected product half is stored rather than the full product, since
    // mode, extension and overflow are all resolved before the first register.
    typedef struct packed {
        logic [DATA_WIDTH-1:0]    data;
        logic [ROB_ID_WIDTH-1:0]  rob_id;
        logic [PC_WIDTH-1:0]      pc;
        logic [RF_ADDR_WIDTH-1:0] rd;
        logic [XCPT_WIDTH-1:0]    xcpt;
        logic                     overflow;
    } mul_stage_t;

    localparam int SW = $bits(mul_stage_t);

    // Index 0 is the request side, index STAGES is the response side.
    logic          s_valid [STAGES+1];
    logic          s_ready [STAGES+1];
    logic [SW-1:0] s_data  [STAGES+1];

    mul_mode_t                 mode;
    logic [2*DATA_WIDTH-1:0]   a_ext;
    logic [2*DATA_WIDTH-1:0]   b_ext;
    logic [2*DATA_WIDTH-1:0]   prod;
    logic [DATA_WIDTH-1:0]     prod_lo;
    logic [DATA_WIDTH-1:0]     prod_hi;
    logic                      ovf_raw;
    mul_stage_t                stage_in;
    mul_stage_t                rsp_stage;

    assign mode = mul_mode_t'(req_mode);

    // Operand extension and full-width product; truncating the 2W x 2W
    // product to 2W bits gives the correct signed or unsigned result.
    always_comb begin
        a_ext = {{DATA_WIDTH{1'b0}}, req_src_a};
        b_ext = {{DATA_WIDTH{1'b0}}, req_src_b};
        if (mode_is_signed(mode)) begin
            a_ext = {{DATA_WIDTH{req_src_a[DATA_WIDTH-1]}}, req_src_a};
            b_ext = {{DATA_WIDTH{req_src_b[DATA_WIDTH-1]}}, req_src_b};
        end
        prod    = a_ext * b_ext;
        prod_lo = prod[DATA_WIDTH-1:0];
        prod_hi = prod[2*DATA_WIDTH-1:DATA_WIDTH];
    end

    // Overflow only applies to the low-half modes: the discarded high half
    // must be pure extension of the returned low half.
    always_comb begin
        ovf_raw = 1'b0;
        case (mode)
            MUL:     ovf_raw = (prod_hi != {DATA_WIDTH{prod_lo[DATA_WIDTH-1]}});
            MULU:    ovf_raw = (prod_hi != '0);
            default: ovf_raw = 1'b0;
        endcase
    end

    // Result selection; an upstream exception suppresses data and overflow
    // but the operation still travels the pipe so the RoB sees it in order.
    always_comb begin
        stage_in          = '0;
        stage_in.rob_id   = req_rob_id;
        stage_in.pc       = req_pc;
        stage_in.rd       = req_rd;
        stage_in.xcpt     = req_xcpt;
        stage_in.data     = mode_is_high(mode) ? prod_hi : prod_lo;
        stage_in.overflow = ovf_raw;
        if (|req_xcpt) begin
            stage_in.data     = '0;
            stage_in.overflow = 1'b0;
        end
    end

    assign s_valid[0]      = req_valid;
    assign s_data[0]       = stage_in;
    assign s_ready[STAGES] = rsp_ready;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            mul_pipe_stage #(
                .WIDTH (SW)
            ) u_stage (
                .clock     (clock),
                .reset     (reset),
                .flush     (flush),
                .in_valid  (s_valid[gi]),
                .in_ready  (s_ready[gi]),
                .in_data   (s_data[gi]),
                .out_valid (s_valid[gi+1]),
                .out_ready (s_ready[gi+1]),
                .out_data  (s_data[gi+1])
            );
        end
    endgenerate

    // The slice ready already drops during flush; reset gating keeps the
    // request side closed while the pipe is held in reset.
    assign req_ready = s_ready[0] && reset;
    assign rsp_valid = s_valid[STAGES] && !flush;

    assign rsp_stage    = mul_stage_t'(s_data[STAGES]);
    assign rsp_data     = rsp_stage.data;
    assign rsp_rob_id   = rsp_stage.rob_id;
    assign rsp_pc       = rsp_stage.pc;
    assign rsp_rd       = rsp_stage.rd;
    assign rsp_xcpt     = rsp_stage.xcpt;
    assign rsp_overflow = rsp_stage.overflow;

    // Busy whenever any slice holds an operation.
    always_comb begin
        busy = 1'b0;
        for (int i = 1; i <= STAGES; i++) begin
            busy = busy | s_valid[i];
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed vector table, backpressure,
// flush and reset sequences, then random traffic against a queue model.
module tb_mul_pipe;

    localparam int DW = 32;
    localparam int L  = 3;
    localparam int RW = 4;
    localparam int PW = 32;
    localparam int AW = 5;
    localparam int XW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_mode = 2'b00;
    logic [DW-1:0] req_src_a = '0;
    logic [DW-1:0] req_src_b = '0;
    logic [RW-1:0] req_rob_id = '0;
    logic [PW-1:0] req_pc = '0;
    logic [AW-1:0] req_rd = '0;
    logic [XW-1:0] req_xcpt = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [RW-1:0] rsp_rob_id;
    logic [PW-1:0] rsp_pc;
    logic [AW-1:0] rsp_rd;
    logic [XW-1:0] rsp_xcpt;
    logic          rsp_overflow;
    logic          busy;

    always #5 clock = ~clock;

    mul_pipe #(
        .DATA_WIDTH(DW), .LATENCY(L), .ROB_ID_WIDTH(RW),
        .PC_WIDTH(PW), .RF_ADDR_WIDTH(AW), .XCPT_WIDTH(XW)
    ) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_src_a(req_src_a), .req_src_b(req_src_b), .req_rob_id(req_rob_id),
        .req_pc(req_pc), .req_rd(req_rd), .req_xcpt(req_xcpt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_rob_id(rsp_rob_id), .rsp_pc(rsp_pc), .rsp_rd(rsp_rd),
        .rsp_xcpt(rsp_xcpt), .rsp_overflow(rsp_overflow), .busy(busy)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [RW-1:0] rob;
        logic [PW-1:0] pc;
        logic [AW-1:0] rd;
        logic [XW-1:0] xcpt;
        logic          ovf;
        int            acc;
    } exp_t;

    typedef struct {
        logic [1:0]    mode;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [XW-1:0] xcpt;
        logic [DW-1:0] data;
        logic          ovf;
    } vec_t;

    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   last_cons = -100;
    int   rsp_count = 0;
    int   acc_count = 0;
    int   last_lat = 0;
    logic acc_flag = 1'b0;
    logic s_req_ready = 1'b0;
    logic s_rsp_valid = 1'b0;
    exp_t last_rsp;
    exp_t q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic, overflow as a range test.
    function automatic exp_t model(input logic [1:0] mode, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [RW-1:0] rob,
                                   input logic [PW-1:0] pc, input logic [AW-1:0] rd,
                                   input logic [XW-1:0] xcpt, input int acc);
        exp_t          e;
        int            sa;
        int            sb;
        longint        sp;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        ua = {32'h0, a};
        ub = {32'h0, b};
        up = ua * ub;
        e.rob = rob; e.pc = pc; e.rd = rd; e.xcpt = xcpt; e.acc = acc;
        e.ovf = 1'b0;
        case (mode)
            2'b00: begin
                e.data = sp[31:0];
                e.ovf  = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
            end
            2'b01: begin
                e.data = up[31:0];
                e.ovf  = (up > 64'h0000_0000_FFFF_FFFF);
            end
            2'b10:   e.data = sp[63:32];
            default: e.data = up[63:32];
        endcase
        if (xcpt != '0) begin
            e.data = '0;
            e.ovf  = 1'b0;
        end
        return e;
    endfunction

    // Per-cycle monitor, run at the falling edge while inputs are stable.
    task automatic observe();
        logic exp_rv;
        logic exp_rr;
        int   vis;
        exp_t e;
        cyc++;
        acc_flag    = 1'b0;
        s_req_ready = req_ready;
        s_rsp_valid = rsp_valid;
        if (!reset) begin
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req_ready", req_ready, 0);
            q.delete();
            last_cons = -100;
            return;
        end
        exp_rv = 1'b0;
        if (!flush && q.size() > 0) begin
            vis = q[0].acc + L;
            if (last_cons + 1 > vis) vis = last_cons + 1;
            exp_rv = (vis <= cyc);
        end
        exp_rr = !flush && ((q.size() < L) || rsp_ready);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("req_ready", req_ready, exp_rr);
        chk("busy", busy, q.size() != 0);
        if (flush) begin
            q.delete();
            last_cons = -100;
            return;
        end
        if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 1, 0);
            end else begin
                e = q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_overflow", rsp_overflow, e.ovf);
                chk("rsp_rob_id", rsp_rob_id, e.rob);
                chk("rsp_pc", rsp_pc, e.pc);
                chk("rsp_rd", rsp_rd, e.rd);
                chk("rsp_xcpt", rsp_xcpt, e.xcpt);
                last_cons = cyc;
                last_lat  = cyc - e.acc;
                last_rsp.data = rsp_data; last_rsp.ovf = rsp_overflow;
                last_rsp.rob = rsp_rob_id; last_rsp.rd = rsp_rd;
                last_rsp.xcpt = rsp_xcpt; last_rsp.pc = rsp_pc;
                rsp_count++;
            end
        end
        if (req_valid && req_ready) begin
            q.push_back(model(req_mode, req_src_a, req_src_b, req_rob_id,
                              req_pc, req_rd, req_xcpt, cyc));
            acc_flag = 1'b1;
            acc_count++;
        end
    endtask

    task automatic tick();
        @(negedge clock);
        observe();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [1:0] mode, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [RW-1:0] rob, input logic [AW-1:0] rd, input logic [XW-1:0] x);
        req_mode = mode; req_src_a = a; req_src_b = b; req_rob_id = rob;
        req_rd = rd; req_xcpt = x; req_pc = $urandom;
    endtask

    // Issue one request with no backpressure and check its result and latency.
    task automatic run_one(input vec_t v, input logic [RW-1:0] rob, input logic [AW-1:0] rd);
        int n0;
        int a0;
        n0 = rsp_count;
        a0 = acc_count;
        drive(v.mode, v.a, v.b, rob, rd, v.xcpt);
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        chk("accepted", acc_count, a0 + 1);
        for (int k = 0; k < 12 && rsp_count == n0; k++) tick();
        chk("rsp_arrived", rsp_count, n0 + 1);
        chk("vec_data", last_rsp.data, v.data);
        chk("vec_overflow", last_rsp.ovf, v.ovf);
        chk("vec_xcpt", last_rsp.xcpt, v.xcpt);
        chk("vec_rob", last_rsp.rob, rob);
        chk("vec_rd", last_rsp.rd, rd);
        chk("vec_latency", last_lat, L);
    endtask

    function automatic logic [DW-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs[12];

    initial begin
        int   next;
        int   stall_left;
        int   sidx;
        logic started;
        int   n0;

        vecs[0]  = '{2'b01, 32'h0001_0000, 32'h0001_0000, 8'h00, 32'h0000_0000, 1'b1};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 8'h00, 32'hFFFF_FFEB, 1'b0};
        vecs[2]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 8'h00, 32'h4000_0000, 1'b0};
        vecs[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 32'hFFFF_FFFE, 1'b0};
        vecs[4]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 8'h04, 32'h0000_0000, 1'b0};
        vecs[5]  = '{2'b00, 32'h7FFF_FFFF, 32'h0000_0002, 8'h00, 32'hFFFF_FFFE, 1'b1};
        vecs[6]  = '{2'b00, 32'h8000_0000, 32'h0000_0001, 8'h00, 32'h8000_0000, 1'b0};
        vecs[7]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 32'h0000_0001, 1'b0};
        vecs[8]  = '{2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 8'h00, 32'hFFFF_FFFF, 1'b0};
        vecs[9]  = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 8'h00, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{2'b10, 32'h8000_0000, 32'h7FFF_FFFF, 8'h00, 32'hC000_0000, 1'b0};
        vecs[11] = '{2'b00, 32'h0001_0000, 32'h0000_8000, 8'h00, 32'h8000_0000, 1'b1};

        // Reset state.
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req_ready", req_ready, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_rob_id", rsp_rob_id, 0);
        chk("reset_rsp_pc", rsp_pc, 0);
        chk("reset_rsp_rd", rsp_rd, 0);
        chk("reset_rsp_xcpt", rsp_xcpt, 0);
        chk("reset_rsp_overflow", rsp_overflow, 0);
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("post_reset_req_ready", req_ready, 1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i], (i == 0) ? 4'd5 : 4'(i), 5'd7);
            $display("vec %0d mode=%0d a=%h b=%h -> data=%h ovf=%0d lat=%0d",
                     i, vecs[i].mode, vecs[i].a, vecs[i].b, last_rsp.data, last_rsp.ovf, last_lat);
        end

        // Back-to-back ids 0..9 with a 5-cycle stall at the first response.
        next = 0; stall_left = 0; started = 1'b0;
        n0 = rsp_count;
        for (int c = 0; c < 60 && (next < 10 || q.size() > 0); c++) begin
            req_valid = (next < 10);
            if (next < 10) drive(2'($urandom), rand_op(), rand_op(), 4'(next), 5'(next), 8'h00);
            if (!started && rsp_valid) begin
                started    = 1'b1;
                stall_left = 5;
            end
            rsp_ready = (stall_left == 0);
            sidx = 6 - stall_left;
            tick();
            if (stall_left > 0) begin
                if (sidx == 3) chk("bp_req_ready_low", s_req_ready, 0);
                if (sidx == 5) chk("bp_rsp_held", s_rsp_valid, 1);
                stall_left--;
            end
            if (acc_flag) next++;
        end
        req_valid = 1'b0;
        chk("bp_all_responses", rsp_count - n0, 10);
        $display("backpressure: %0d responses", rsp_count - n0);

        // Flush with three operations in flight and a request pending.
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, rand_op(), rand_op(), 4'(i), 5'd3, 8'h00);
            req_valid = 1'b1;
            tick();
        end
        drive(2'b01, 32'd9, 32'd9, 4'd15, 5'd3, 8'h00);
        flush = 1'b1;
        #1;
        chk("flush_req_ready", req_ready, 0);
        chk("flush_rsp_valid", rsp_valid, 0);
        n0 = rsp_count;
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("flush_no_rsp", rsp_count, n0);
        run_one(vecs[1], 4'd11, 5'd2);
        $display("flush: post-flush data=%h lat=%0d", last_rsp.data, last_lat);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 4; i++) begin
            drive(2'b10, rand_op(), rand_op(), 4'(i), 5'd1, 8'h00);
            req_valid = 1'b1;
            tick();
        end
        chk("pre_reset_rsp_valid", rsp_valid, 1);
        reset = 1'b0;
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_busy", busy, 0);
        req_valid = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("release_req_ready", req_ready, 1);
        run_one(vecs[3], 4'd6, 5'd9);
        $display("reset: first result data=%h lat=%0d", last_rsp.data, last_lat);

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            drive(2'($urandom), rand_op(), rand_op(), 4'($urandom),
                  5'($urandom), ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00);
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end
        flush = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("drain_empty", q.size(), 0);
        $display("random: %0d accepted, %0d responses total", acc_count, rsp_count);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised pipelined integer multiplier, the successor to the fixed-latency MUL unit. It sits between decode/issue and writeback and adds the following over the previous unit:
- configurable width and latency;
- four multiply modes (signed/unsigned, low/high half);
- per-stage valid/ready backpressure in place of a global decode stall;
- full-pipeline flush.

Results carry the RoB id, PC, destination register and the exception bits forwarded from earlier stages.

## Interface
Parameters:
- DATA_WIDTH, 32: operand and result width.
- LATENCY, 3: register stages, from request acceptance to rsp_valid; legal range 1..8.
- ROB_ID_WIDTH, 4: RoB ticket width.
- PC_WIDTH, 32: program counter width.
- RF_ADDR_WIDTH, 5: destination register address width.
- XCPT_WIDTH, 8: forwarded upstream exception vector width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_mode  in  2  00 MUL (signed low), 01 MULU (unsigned low), 10 MULH (signed high), 11 MULHU (unsigned high).
- req_src_a, req_src_b  in  DATA_WIDTH  operands.
- req_rob_id  in  ROB_ID_WIDTH  ticket.
- req_pc  in  PC_WIDTH  instruction PC.
- req_rd  in  RF_ADDR_WIDTH  destination register.
- req_xcpt  in  XCPT_WIDTH  upstream exception bits.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  writeback accepts the result.
- rsp_data  out  DATA_WIDTH  selected product half.
- rsp_rob_id, rsp_pc, rsp_rd, rsp_xcpt  out  echoed request fields.
- rsp_overflow  out  1  overflow exception.
- busy  out  1  any stage valid.

## Operation
Handshakes:
- A request is accepted on a cycle with req_valid & req_ready.
- A response is consumed on a cycle with rsp_valid & rsp_ready.

Product and stage behaviour:
- Stage 1 captures the full 2*DATA_WIDTH product and the request metadata.
- The product is formed from operands sign- or zero-extended according to mode.
- Stages 2..LATENCY only carry registers (retiming-friendly).

Result selection:
- MUL and MULU: rsp_data = low half.
- MULH and MULHU: rsp_data = high half.

Overflow, evaluated in stage 1 and carried down:
- MUL: set when the high half is not the sign-extension of low-half bit DATA_WIDTH-1.
- MULU: set when the high half is nonzero.
- MULH, MULHU: never set.

Upstream exceptions:
- If req_xcpt is nonzero, the operation still flows through the pipeline and rsp_xcpt equals req_xcpt.
- In that case rsp_data = 0 and rsp_overflow = 0.

Advance rule:
- Stage i loads when stage i is empty, or stage i's contents advance this cycle.
- The last stage advances on rsp_ready.
- req_ready = (stage 1 empty or stage 1 advancing) & !flush.
- The ready chain is combinational through all stages.
- A held stage keeps all of its fields unchanged.

Flush:
- All valid bits clear at the next edge.
- Data registers are don't-care after a flush.
- rsp_valid and req_ready are forced 0 in the flush cycle.
- No request is accepted during the flush cycle.
- flush overrides any simultaneous accept or consume.

## Timing
Reset values:
- All stage valids are 0, so rsp_valid = 0 and busy = 0.
- req_ready = 1 once reset deasserts (it is 0 while reset is asserted and during a flush).
- rsp_data, rsp_rob_id, rsp_pc, rsp_rd, rsp_xcpt and rsp_overflow reset to 0.

Reset mid-operation:
- Asynchronous assertion discards all in-flight operations immediately.
- Deassertion is synchronised externally.

Latency and throughput:
- A request accepted at edge t produces rsp_valid in the cycle after edge t+LATENCY-1, i.e. LATENCY cycles, when there is no backpressure.
- Throughput is one operation per cycle.

Backpressure and ordering:
- rsp_ready low holds the last stage; bubbles ahead of it collapse.
- After LATENCY consecutive cycles with rsp_ready low and continuous requests, req_ready goes low.
- Ordering is strictly in order; no operation is dropped or duplicated.
- A simultaneous consume at the last stage and accept at stage 1 with all stages full is legal; occupancy is unchanged.

## Structure
Shared package (mul_pkg):
- mul_mode_t enum (MUL, MULU, MULH, MULHU).
- mul_stage_t struct: valid, prod[2*DATA_WIDTH] or the selected half, rob_id, pc, rd, xcpt, overflow.
- Latency bound constant MUL_MAX_LATENCY = 8.

Sub-module mul_pipe_stage:
- One valid/ready register slice.
- Ports: clock, reset, flush, in_valid, in_ready, in_data, out_valid, out_ready, out_data.
- Instantiated LATENCY times in a generate loop.
- Product, extension and overflow logic live in the top.

## Test plan
- DATA_WIDTH=32, LATENCY=3; MULU 0x0001_0000 × 0x0001_0000, rob 5, rd 7, rsp_ready=1 -> rsp_valid exactly 3 cycles later, data 0x0000_0000, overflow=1, rob 5, rd 7.
- MUL -3 × 7 -> data 0xFFFF_FFEB, overflow=0. MULH 0x8000_0000 × 0x8000_0000 -> data 0x4000_0000, overflow=0. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF -> data 0xFFFF_FFFE.
- 10 back-to-back requests (ids 0..9); rsp_ready low for 5 cycles starting at the first response -> req_ready low after 3 stalled cycles; all 10 responses emerge in id order, none lost.
- flush asserted while 3 operations are in flight and a new req_valid is present -> no rsp_valid thereafter; req_ready=0 in the flush cycle; a next request issued afterwards completes in 3 cycles.
- req_xcpt=0x04 with MULU 0xFFFF_FFFF × 2 -> rsp_xcpt=0x04, data 0, overflow=0.
- Async reset asserted mid-stream -> rsp_valid and busy drop in the same cycle; after release, req_ready=1 and the first new result has latency 3.
